npc_predictor: RTL and testbench

NPC_PREDICTOR -- requirements
Module: npc_predictor

---
 rtl/npc_predictor.sv | 139 +++++++++++++
 tb/tb_npc_predictor.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/npc_predictor.sv
// Next-PC predictor: direct-mapped BTB with per-entry saturating counters.
// Selects the next fetch address from jump, mispredict-recovery and
// prediction sources, and keeps resolved-branch and misprediction counts.
module npc_predictor #(
    parameter int ENTRIES = 64,
    parameter int CNT_W   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_pc,
    input  logic        stall,
    input  logic        jal,
    input  logic [31:0] jal_target,
    input  logic        jalr,
    input  logic [31:0] jalr_target,
    input  logic        ex_br,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    input  logic        ex_taken,
    input  logic        ex_pred_taken,
    output logic [31:0] npc,
    output logic        pred_taken,
    output logic        mispredict,
    output logic [31:0] br_cnt,
    output logic [31:0] miss_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 32 - IDX_W - 2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    // Freshly allocated entries start weakly taken; reset leaves them weakly not-taken.
    localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1 << (CNT_W - 1));
    localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'((1 << (CNT_W - 1)) - 1);

    logic             r_valid  [ENTRIES];
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    logic [31:0]      r_target [ENTRIES];
    logic [CNT_W-1:0] r_cnt    [ENTRIES];
    logic [31:0]      r_br_cnt;
    logic [31:0]      r_miss_cnt;

    logic [IDX_W-1:0] w_if_idx;
    logic [TAG_W-1:0] w_if_tag;
    logic [IDX_W-1:0] w_ex_idx;
    logic [TAG_W-1:0] w_ex_tag;
    logic             w_if_hit;
    logic             w_ex_hit;
    logic [CNT_W-1:0] w_if_cnt;
    logic [CNT_W-1:0] w_ex_cnt;
    logic             w_mispredict;
    logic             w_update;
    logic [31:0]      w_npc;
    logic             w_unused;

    // PCs are word aligned; the byte-offset bits never address the table.
    assign w_unused = ^{if_pc[1:0], ex_pc[1:0]};

    assign w_if_idx = if_pc[IDX_W+1:2];
    assign w_if_tag = if_pc[31:IDX_W+2];
    assign w_ex_idx = ex_pc[IDX_W+1:2];
    assign w_ex_tag = ex_pc[31:IDX_W+2];

    assign w_if_cnt = r_cnt[w_if_idx];
    assign w_ex_cnt = r_cnt[w_ex_idx];
    assign w_if_hit = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
    assign w_ex_hit = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);

    // Flush request is not gated by stall: a wrong path must be squashed regardless.
    assign w_mispredict = ex_br && (ex_taken != ex_pred_taken);
    assign w_update     = ex_br && !stall;

    assign pred_taken = w_if_hit && w_if_cnt[CNT_W-1];
    assign mispredict = w_mispredict;
    assign npc        = w_npc;
    assign br_cnt     = r_br_cnt;
    assign miss_cnt   = r_miss_cnt;

    // Next fetch address, fixed priority from the latest-resolved source down.
    always_comb begin
        w_npc = if_pc + 32'd4;
        if (jalr) begin
            w_npc = jalr_target;
        end else if (w_mispredict && ex_taken) begin
            w_npc = ex_target;
        end else if (w_mispredict) begin
            w_npc = ex_pc + 32'd4;
        end else if (jal) begin
            w_npc = jal_target;
        end else if (pred_taken) begin
            w_npc = r_target[w_if_idx];
        end
    end

    // BTB/BHT training from resolved conditional branches; misses allocate only when taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_cnt[i]    <= CNT_WNT;
            end
        end else if (w_update) begin
            if (w_ex_hit) begin
                if (ex_taken) begin
                    if (w_ex_cnt != CNT_MAX) begin
                        r_cnt[w_ex_idx] <= w_ex_cnt + CNT_ONE;
                    end
                    r_target[w_ex_idx] <= ex_target;
                end else if (w_ex_cnt != '0) begin
                    r_cnt[w_ex_idx] <= w_ex_cnt - CNT_ONE;
                end
            end else if (ex_taken) begin
                r_valid[w_ex_idx]  <= 1'b1;
                r_tag[w_ex_idx]    <= w_ex_tag;
                r_target[w_ex_idx] <= ex_target;
                r_cnt[w_ex_idx]    <= CNT_WT;
            end
        end
    end

    // Resolved-branch and misprediction statistics, wrapping at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_br_cnt   <= '0;
            r_miss_cnt <= '0;
        end else if (!stall) begin
            if (ex_br) begin
                r_br_cnt <= r_br_cnt + 32'd1;
            end
            if (w_mispredict) begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_npc_predictor.sv
// Randomized and directed bench for npc_predictor against a table-level model.
module tb_npc_predictor;

    localparam int ENTRIES = 64;
    localparam int CNT_W   = 2;
    localparam int IDX_W   = 6;
    localparam int CNT_TOP = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] if_pc = '0;
    logic        stall = 1'b0;
    logic        jal = 1'b0;
    logic [31:0] jal_target = '0;
    logic        jalr = 1'b0;
    logic [31:0] jalr_target = '0;
    logic        ex_br = 1'b0;
    logic [31:0] ex_pc = '0;
    logic [31:0] ex_target = '0;
    logic        ex_taken = 1'b0;
    logic        ex_pred_taken = 1'b0;
    logic [31:0] npc;
    logic        pred_taken;
    logic        mispredict;
    logic [31:0] br_cnt;
    logic [31:0] miss_cnt;

    npc_predictor #(.ENTRIES(ENTRIES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .stall(stall),
        .jal(jal), .jal_target(jal_target), .jalr(jalr), .jalr_target(jalr_target),
        .ex_br(ex_br), .ex_pc(ex_pc), .ex_target(ex_target), .ex_taken(ex_taken),
        .ex_pred_taken(ex_pred_taken), .npc(npc), .pred_taken(pred_taken),
        .mispredict(mispredict), .br_cnt(br_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: one record per table slot, plus two statistics counters.
    bit          m_valid [ENTRIES];
    logic [31:0] m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_cnt   [ENTRIES];
    logic [31:0] m_br;
    logic [31:0] m_miss;

    function automatic int slot(input logic [31:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] pc);
        return pc / (4 * ENTRIES);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[slot(pc)] && (m_tag[slot(pc)] == tag_of(pc));
    endfunction

    function automatic bit m_pred(input logic [31:0] pc);
        return m_hit(pc) && (m_cnt[slot(pc)] >= (CNT_TOP + 1) / 2);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
            m_tgt[i]   = '0;
            m_cnt[i]   = (CNT_TOP + 1) / 2 - 1;
        end
        m_br   = '0;
        m_miss = '0;
    endtask

    task automatic check_all();
        bit          pt;
        bit          mp;
        logic [31:0] exp_npc;
        if (!rst_n) model_reset();
        pt = m_pred(if_pc);
        mp = ex_br && (ex_taken != ex_pred_taken);
        if (jalr)                 exp_npc = jalr_target;
        else if (mp && ex_taken)  exp_npc = ex_target;
        else if (mp)              exp_npc = ex_pc + 32'd4;
        else if (jal)             exp_npc = jal_target;
        else if (pt)              exp_npc = m_tgt[slot(if_pc)];
        else                      exp_npc = if_pc + 32'd4;
        chk("npc", npc, exp_npc);
        chk("pred_taken", 32'(pred_taken), 32'(pt));
        chk("mispredict", 32'(mispredict), 32'(mp));
        chk("br_cnt", br_cnt, m_br);
        chk("miss_cnt", miss_cnt, m_miss);
    endtask

    task automatic model_update();
        int s;
        if (!rst_n || stall || !ex_br) return;
        s = slot(ex_pc);
        m_br = m_br + 32'd1;
        if (ex_taken != ex_pred_taken) m_miss = m_miss + 32'd1;
        if (m_hit(ex_pc)) begin
            if (ex_taken) begin
                m_cnt[s] = (m_cnt[s] < CNT_TOP) ? m_cnt[s] + 1 : CNT_TOP;
                m_tgt[s] = ex_target;
            end else begin
                m_cnt[s] = (m_cnt[s] > 0) ? m_cnt[s] - 1 : 0;
            end
        end else if (ex_taken) begin
            m_valid[s] = 1'b1;
            m_tag[s]   = tag_of(ex_pc);
            m_tgt[s]   = ex_target;
            m_cnt[s]   = (CNT_TOP + 1) / 2;
        end
    endtask

    // One cycle: inputs already driven just after a rising edge.
    task automatic cyc();
        #2;
        check_all();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        jal = 0; jalr = 0; ex_br = 0; ex_taken = 0; ex_pred_taken = 0; stall = 0;
    endtask

    task automatic resolve(input logic [31:0] pc, input bit tk, input bit pr, input logic [31:0] tgt);
        ex_br = 1; ex_pc = pc; ex_taken = tk; ex_pred_taken = pr; ex_target = tgt;
        cyc();
    endtask

    function automatic logic [31:0] pick_pc();
        int r;
        r = int'($urandom_range(15));
        if (r == 0) return $urandom & 32'hFFFF_FFFC;
        if (r == 1) return 32'hFFFF_FFFC;
        return (32'($urandom_range(3)) << 8) | (32'($urandom_range(7)) << 2);
    endfunction

    initial begin
        model_reset();
        #2;
        check_all();
        chk("rst_br_cnt", br_cnt, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1;
        #1;
        chk("rel_npc", npc, 32'd4);
        chk("rel_pred", 32'(pred_taken), 32'd0);
        cyc();

        // Cold miss
        if_pc = 32'h100;
        #1;
        chk("cold_npc", npc, 32'h104);
        cyc();

        // Allocate then predict
        ex_br = 1; ex_pc = 32'h100; ex_taken = 1; ex_pred_taken = 0; ex_target = 32'h40;
        #1;
        chk("alloc_mp", 32'(mispredict), 32'd1);
        chk("alloc_npc", npc, 32'h40);
        cyc();
        idle();
        #1;
        chk("pred_hit", 32'(pred_taken), 32'd1);
        chk("pred_npc", npc, 32'h40);
        chk("pred_br", br_cnt, 32'd1);
        chk("pred_miss", miss_cnt, 32'd1);
        cyc();

        // Saturation at both ends
        repeat (3) resolve(32'h100, 0, 1, 32'h40);
        idle();
        #1;
        chk("sat_lo_pred", 32'(pred_taken), 32'd0);
        cyc();
        repeat (4) resolve(32'h100, 1, 0, 32'h44);
        repeat (5) resolve(32'h100, 1, 1, 32'h48);
        resolve(32'h100, 0, 1, 32'h48);
        idle();
        #1;
        chk("sat_hi_pred", 32'(pred_taken), 32'd1);
        cyc();

        // Priority
        jalr = 1; jalr_target = 32'h200; jal = 1; jal_target = 32'h300;
        ex_br = 1; ex_pc = 32'h80; ex_taken = 0; ex_pred_taken = 1;
        #1; chk("prio_jalr", npc, 32'h200); cyc();
        jalr = 0;
        #1; chk("prio_mp", npc, 32'h84); cyc();
        ex_br = 0;
        #1; chk("prio_jal", npc, 32'h300); cyc();
        idle();

        // PC+4 wrap
        ex_br = 1; ex_pc = 32'hFFFF_FFFC; ex_taken = 0; ex_pred_taken = 1;
        #1; chk("wrap_npc", npc, 32'h0); cyc();
        idle();

        // Aliasing overwrite
        resolve(32'h1100, 1, 0, 32'h500);
        idle();
        if_pc = 32'h100;
        #1; chk("alias_npc", npc, 32'h104); cyc();

        // Stall blocks updates, mispredict still visible
        stall = 1;
        resolve(32'h1100, 0, 1, 32'h0);
        resolve(32'h1100, 0, 1, 32'h0);
        idle();
        if_pc = 32'h1100;
        #1; chk("stall_pred", 32'(pred_taken), 32'd1); cyc();

        // Mid-run reset clears immediately
        rst_n = 0;
        #1;
        chk("mrst_br", br_cnt, 32'd0);
        chk("mrst_pred", 32'(pred_taken), 32'd0);
        cyc();
        rst_n = 1;
        cyc();

        // Reset held across an update edge
        rst_n = 0;
        resolve(32'h200, 1, 0, 32'h600);
        rst_n = 1;
        idle();
        if_pc = 32'h200;
        #1; chk("rst_upd_pred", 32'(pred_taken), 32'd0); cyc();

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            rst_n         = ($urandom_range(149) != 0);
            stall         = ($urandom_range(4) == 0);
            jal           = ($urandom_range(7) == 0);
            jalr          = ($urandom_range(9) == 0);
            jal_target    = $urandom & 32'hFFFF_FFFC;
            jalr_target   = $urandom & 32'hFFFF_FFFC;
            ex_br         = 1'($urandom_range(1));
            ex_pc         = pick_pc();
            if_pc         = pick_pc();
            ex_taken      = 1'($urandom_range(1));
            ex_target     = $urandom & 32'hFFFF_FFFC;
            ex_pred_taken = m_pred(ex_pc) ^ ($urandom_range(3) == 0);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
